seg_scroll: RTL and testbench
=============================

SEG_SCROLL -- requirements
Module: seg_scroll

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, meaning the number of displayed 7-segment digits.
REQ-002 SHALL have parameter MSG_LEN, default 16, meaning message buffer depth in glyphs; legal when MSG_LEN >= NUM_DIGITS, and need not be a power of two.
REQ-003 SHALL have parameter TICK_DIV, default 500000, meaning clk cycles per scroll tick; legal when >= 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port wr_en, input, 1 bit: write strobe for the message buffer.
REQ-007 SHALL have port wr_addr, input, $clog2(MSG_LEN) bits: buffer write index.
REQ-008 SHALL have port wr_data, input, 8 bits: glyph written, with bit 7 = segment a … bit 0 = dp, active-high.
REQ-009 SHALL have port run, input, 1 bit: enables automatic scrolling.
REQ-010 SHALL have port dir, input, 1 bit: 0 = offset increments, 1 = offset decrements.
REQ-011 SHALL have port step, input, 1 bit: single-cycle manual advance request.
REQ-012 SHALL have port blink, input, 1 bit: blank-blink request, used only under REQ-029.
REQ-013 SHALL have port o_seg, output, NUM_DIGITS*8 bits: digit i occupies bits [8i+7:8i], active-low.
REQ-014 SHALL have port o_offset, output, $clog2(MSG_LEN) bits: current scroll offset.
REQ-015 SHALL have port o_wrap, output, 1 bit: one-cycle pulse on offset wrap-around.

Function
REQ-016 Divider SHALL free-run 0..TICK_DIV-1 regardless of run, asserting an internal tick in the cycle count==TICK_DIV-1, with count returning to 0 on the next cycle.
REQ-017 The offset SHALL advance by one when (tick && run) || step; tick and step in the same cycle SHALL produce a single advance.
REQ-018 Advance arithmetic SHALL be: dir=0 gives offset = (offset==MSG_LEN-1) ? 0 : offset+1; dir=1 gives offset = (offset==0) ? MSG_LEN-1 : offset-1.
REQ-019 o_wrap SHALL be 1 in exactly the cycle o_offset takes its wrapped value (0 for dir=0, MSG_LEN-1 for dir=1), and 0 otherwise.
REQ-020 Digit i SHALL display ~buf[(offset+i) mod MSG_LEN]; the modulo SHALL be exact for non-power-of-two MSG_LEN.
REQ-021 o_seg SHALL be registered: it reflects an offset change one cycle after o_offset changes.
REQ-022 A write with wr_en=1 and wr_addr < MSG_LEN SHALL update buf at the clock edge; the write SHALL be visible on o_seg two cycles after wr_en is sampled.
REQ-023 A write with wr_addr >= MSG_LEN SHALL be ignored.
REQ-024 A write and an advance in the same cycle SHALL both take effect.
REQ-025 A dir change SHALL take effect on the next advance; no advance SHALL occur while run=0 and step=0.

Reset
REQ-026 With rst_n=0, the block SHALL asynchronously set divider=0, offset=0, o_wrap=0, o_seg all ones (all segments off), all buf entries=8'h00, and blink phase=0.
REQ-027 Deassertion of rst_n SHALL be synchronous to clk, and the first tick SHALL occur TICK_DIV cycles after deassertion.
REQ-028 Reset asserted mid-scroll SHALL discard buffer contents; no partial state SHALL survive.

Configuration
REQ-029 With macro SEG_SCROLL_BLINK_EN defined, a phase bit SHALL toggle on every tick; while blink=1 and phase=1, o_seg SHALL be forced to all ones.
REQ-030 With SEG_SCROLL_BLINK_EN defined, the offset, o_wrap and buffer SHALL be unaffected by blink.
REQ-031 Without SEG_SCROLL_BLINK_EN, the blink port SHALL remain present but be ignored, and no phase register SHALL be built.

Structure
REQ-032 Package seg_pkg SHALL hold the glyph type (8-bit), glyph constants SEG_BLANK and SEG_DIGIT_0..SEG_DIGIT_9, and the segment bit-order definition.
REQ-033 The divider SHALL be the sub-module seg_tick_div, with parameter TICK_DIV, inputs clk and rst_n, and a 1-bit output tick.
REQ-034 The buffer SHALL be flops, not inferred RAM, to allow all-digit parallel read.

Verification
(Benches run with TICK_DIV=4, NUM_DIGITS=4, MSG_LEN=6.)
REQ-035 Bench SHALL check: reset, then load buf[k]=k+1 for k=0..5 -> o_seg digits = ~{1,2,3,4} two cycles after the last write, and o_offset=0.
REQ-036 Bench SHALL check: run=1, dir=0 for 6 ticks -> o_offset sequence 1,2,3,4,5,0; o_wrap pulses once with offset 0; digit0 after wrap = ~1.
REQ-037 Bench SHALL check: offset=0 and dir=1 with step pulse -> o_offset=5, o_wrap=1 for one cycle, digits = ~{6,1,2,3}.
REQ-038 Bench SHALL check: step coincident with a run tick -> the offset advances by exactly 1.
REQ-039 Bench SHALL check: write at wr_addr=6 -> buffer is unchanged; a write to the currently displayed index during an advance -> both effects are visible.
REQ-040 Bench SHALL check: with SEG_SCROLL_BLINK_EN defined and blink=1 -> o_seg alternates all-ones and message each tick; rst_n pulsed mid-run -> o_seg is all ones immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - glyph type, segment bit order and glyph constants shared by seg_scroll
package seg_pkg;

    typedef logic [7:0] glyph_t;

    // Glyph bit order, active-high: bit 7 = segment a down to bit 0 = decimal point
    localparam int SEG_BIT_A  = 7;
    localparam int SEG_BIT_B  = 6;
    localparam int SEG_BIT_C  = 5;
    localparam int SEG_BIT_D  = 4;
    localparam int SEG_BIT_E  = 3;
    localparam int SEG_BIT_F  = 2;
    localparam int SEG_BIT_G  = 1;
    localparam int SEG_BIT_DP = 0;

    localparam glyph_t SEG_BLANK   = 8'h00;
    localparam glyph_t SEG_DIGIT_0 = 8'hFC;
    localparam glyph_t SEG_DIGIT_1 = 8'h60;
    localparam glyph_t SEG_DIGIT_2 = 8'hDA;
    localparam glyph_t SEG_DIGIT_3 = 8'hF2;
    localparam glyph_t SEG_DIGIT_4 = 8'h66;
    localparam glyph_t SEG_DIGIT_5 = 8'hB6;
    localparam glyph_t SEG_DIGIT_6 = 8'hBE;
    localparam glyph_t SEG_DIGIT_7 = 8'hE0;
    localparam glyph_t SEG_DIGIT_8 = 8'hFE;
    localparam glyph_t SEG_DIGIT_9 = 8'hF6;

endpackage

// File: rtl/seg_tick_div.sv
// rtl/seg_tick_div.sv - free-running divider, tick high while count == TICK_DIV-1
module seg_tick_div #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    import seg_pkg::*;

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/seg_scroll.sv
// rtl/seg_scroll.sv - scrolling 7-segment message display; define SEG_SCROLL_BLINK_EN for blank-blink
module seg_scroll #(
    parameter int NUM_DIGITS = 8,
    parameter int MSG_LEN    = 16,
    parameter int TICK_DIV   = 500000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]  wr_addr,
    input  logic [7:0]                  wr_data,
    input  logic                        run,
    input  logic                        dir,
    input  logic                        step,
    input  logic                        blink,
    output logic [NUM_DIGITS*8-1:0]     o_seg,
    output logic [$clog2(MSG_LEN)-1:0]  o_offset,
    output logic                        o_wrap
);
    import seg_pkg::*;

    localparam int AW = $clog2(MSG_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(MSG_LEN - 1);

    logic                    tick;
    logic                    advance;
    logic                    blank;
    logic [AW-1:0]           offset_q;
    logic [AW-1:0]           offset_d;
    logic                    wrap_q;
    logic                    wrap_d;
    logic [NUM_DIGITS*8-1:0] seg_q;
    logic [NUM_DIGITS*8-1:0] seg_d;
    glyph_t                  buf_q [MSG_LEN];
    glyph_t                  buf_d [MSG_LEN];

    seg_tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // offset + i never reaches 2*MSG_LEN, so one conditional subtract is an exact modulo
    function automatic logic [AW-1:0] rd_idx(input logic [AW-1:0] off, input int i);
        int s;
        s = int'(off) + i;
        if (s >= MSG_LEN) begin
            s = s - MSG_LEN;
        end
        return AW'(s);
    endfunction

    assign advance = (tick && run) || step;

    always_comb begin
        offset_d = offset_q;
        wrap_d   = 1'b0;
        if (advance) begin
            if (!dir) begin
                wrap_d   = (offset_q == LAST_IDX);
                offset_d = wrap_d ? '0 : offset_q + AW'(1);
            end else begin
                wrap_d   = (offset_q == '0);
                offset_d = wrap_d ? LAST_IDX : offset_q - AW'(1);
            end
        end
    end

    always_comb begin
        buf_d = buf_q;
        if (wr_en && (int'(wr_addr) < MSG_LEN)) begin
            buf_d[wr_addr] = wr_data;
        end
    end

`ifdef SEG_SCROLL_BLINK_EN
    logic phase_q;
    logic phase_d;

    always_comb begin
        phase_d = tick ? ~phase_q : phase_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign blank = blink && phase_q;
`else
    logic unused_blink;
    assign unused_blink = blink;
    assign blank        = 1'b0;
`endif

    // Output is active-low, so a blanked display is all ones
    always_comb begin
        seg_d = '1;
        if (!blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seg_d[8*i +: 8] = ~buf_q[rd_idx(offset_q, i)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q <= '0;
            wrap_q   <= 1'b0;
            seg_q    <= '1;
            buf_q    <= '{default: SEG_BLANK};
        end else begin
            offset_q <= offset_d;
            wrap_q   <= wrap_d;
            seg_q    <= seg_d;
            buf_q    <= buf_d;
        end
    end

    assign o_seg    = seg_q;
    assign o_offset = offset_q;
    assign o_wrap   = wrap_q;

endmodule

// File: tb/tb_seg_scroll.sv
// tb/tb_seg_scroll.sv - scoreboard bench for seg_scroll (TICK_DIV=4, NUM_DIGITS=4, MSG_LEN=6)
module tb_seg_scroll;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        run = 1'b0;
    logic        dir = 1'b0;
    logic        step = 1'b0;
    logic        blink = 1'b0;
    logic [31:0] o_seg;
    logic [2:0]  o_offset;
    logic        o_wrap;

    seg_scroll #(
        .NUM_DIGITS(4),
        .MSG_LEN   (6),
        .TICK_DIV  (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .run     (run),
        .dir     (dir),
        .step    (step),
        .blink   (blink),
        .o_seg   (o_seg),
        .o_offset(o_offset),
        .o_wrap  (o_wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mask bit0 = offset, bit1 = wrap, bit2 = segments
    typedef struct {
        int          cyc;
        string       name;
        logic [2:0]  mask;
        int          off;
        logic        wrap;
        logic [31:0] seg;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int pass_cnt = 0;
    int total_cnt = 0;
    int rst_cyc = 0;

    localparam logic [31:0] MSG_LOAD = {8'hFB, 8'hFC, 8'hFD, 8'hFE};
    localparam logic [31:0] MSG_OFF1 = {8'hFA, 8'hFB, 8'hFC, 8'hFD};
    localparam logic [31:0] MSG_OFF5 = {8'hFC, 8'hFD, 8'hFE, 8'hF9};
    localparam logic [31:0] MSG_WR77 = {8'hFA, 8'hFB, 8'hFC, 8'h88};

    task automatic push(input int c, input string n, input logic [2:0] m,
                        input int off, input logic w, input logic [31:0] s);
        exp_t x;
        x.cyc = c; x.name = n; x.mask = m; x.off = off; x.wrap = w; x.seg = s;
        q.push_back(x);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", n, act, req, cyc);
    endtask

    always @(negedge clk or negedge rst_n) begin
        #1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                total_cnt++;
                $display("FAIL %s: not sampled, due cycle %0d, now %0d", e.name, e.cyc, cyc);
            end else begin
                if (e.mask[0]) chk({e.name, "_offset"}, 32'(o_offset), 32'(e.off));
                if (e.mask[1]) chk({e.name, "_wrap"}, 32'(o_wrap), 32'(e.wrap));
                if (e.mask[2]) chk({e.name, "_seg"}, o_seg, e.seg);
            end
        end
    end

    task automatic tick_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_phase(input int p);
        @(negedge clk);
        while (((cyc - rst_cyc) % 4) != p) @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, c, s, p, w, x, due, last_wr;
        logic blank;
        exp_t left;

        push(2, "reset", 3'b111, 0, 1'b0, '1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rst_cyc = cyc;

        // Load buf[k] = k+1
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 3'(k); wr_data = 8'(k + 1);
            last_wr = cyc;
        end
        @(negedge clk);
        wr_en = 1'b0;
        push(last_wr + 2, "load", 3'b111, 0, 1'b0, MSG_LOAD);
        tick_to(last_wr + 2);

        // Automatic scroll forward through one full wrap
        wait_phase(0);
        b = cyc;
        run = 1'b1; dir = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            push(b + 4*t, $sformatf("run%0d", t), 3'b011, t % 6, t == 6, '0);
            if (t == 1) push(b + 5, "run1", 3'b100, 1, 1'b0, MSG_OFF1);
            if (t == 6) push(b + 25, "after_wrap", 3'b111, 0, 1'b0, MSG_LOAD);
            push(b + 4*t + 2, $sformatf("run%0d_hold", t), 3'b011, t % 6, 1'b0, '0);
        end
        push(b + 29, "stopped", 3'b011, 0, 1'b0, '0);
        tick_to(b + 25);
        run = 1'b0;
        tick_to(b + 29);

        // Manual step backwards from 0 wraps to MSG_LEN-1
        @(negedge clk);
        s = cyc;
        dir = 1'b1; step = 1'b1;
        push(s + 1, "step_back", 3'b011, 5, 1'b1, '0);
        push(s + 2, "step_back_after", 3'b111, 5, 1'b0, MSG_OFF5);
        @(negedge clk);
        step = 1'b0;
        tick_to(s + 2);

        // Step coincident with a run tick gives a single advance
        wait_phase(3);
        p = cyc;
        run = 1'b1; step = 1'b1; dir = 1'b0;
        push(p + 1, "coincident", 3'b011, 0, 1'b1, '0);
        @(negedge clk);
        run = 1'b0; step = 1'b0;
        push(p + 3, "coincident_hold", 3'b011, 0, 1'b0, '0);
        tick_to(p + 3);

        // Out-of-range write is dropped
        @(negedge clk);
        w = cyc;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'hAA;
        @(negedge clk);
        wr_en = 1'b0;
        push(w + 2, "bad_addr", 3'b111, 0, 1'b0, MSG_LOAD);
        tick_to(w + 2);

        // Write to a displayed index in the same cycle as an advance
        @(negedge clk);
        x = cyc;
        step = 1'b1; dir = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h77;
        push(x + 1, "wr_adv", 3'b011, 1, 1'b0, '0);
        push(x + 2, "wr_adv_after", 3'b111, 1, 1'b0, MSG_WR77);
        @(negedge clk);
        step = 1'b0; wr_en = 1'b0;
        tick_to(x + 2);

        // Blink request: blanks on odd phase when the feature is built, ignored otherwise
        blink = 1'b1;
        wait_phase(2);
        c = cyc;
        for (int j = 1; j <= 4; j++) begin
            due = c + 4*j;
`ifdef SEG_SCROLL_BLINK_EN
            blank = (((due - 1 - rst_cyc) / 4) % 2) == 1;
`else
            blank = 1'b0;
`endif
            push(due, $sformatf("blink%0d", j), 3'b101, 1, 1'b0, blank ? 32'hFFFF_FFFF : MSG_WR77);
        end
        tick_to(c + 16);
        blink = 1'b0;

        // Asynchronous reset mid-run
        run = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        push(cyc, "async_reset", 3'b111, 0, 1'b0, '1);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rst_cyc = cyc;
        push(rst_cyc + 3, "post_reset", 3'b111, 0, 1'b0, '1);
        push(rst_cyc + 4, "first_tick", 3'b011, 1, 1'b0, '0);
        tick_to(rst_cyc + 5);
        run = 1'b0;

        repeat (3) @(negedge clk);
        while (q.size() > 0) begin
            left = q.pop_front();
            total_cnt++;
            $display("FAIL %s: never sampled, due cycle %0d", left.name, left.cyc);
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
